regbank_write_arbiter: RTL and testbench
========================================

REGBANK_WRITE_ARBITER -- requirements
Module: regbank_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, width of one flip-flop bank word.
REQ-002 Parameter ADDR_W, default 3, bank word address width (8 words).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port a_req  input  1  requester A write request, level.
REQ-006 Port a_addr  input  ADDR_W  requester A target word.
REQ-007 Port a_data  input  DATA_W  requester A write data.
REQ-008 Port a_ack  output  1  one-cycle pulse: A's write committed.
REQ-009 Port b_req, b_addr, b_data, b_ack  same widths and meanings as A, for requester B.
REQ-010 Port wr_en  output  1  bank write enable, high for exactly one cycle per write.
REQ-011 Port wr_addr  output  ADDR_W  bank write address, registered.
REQ-012 Port wr_data  output  DATA_W  bank write data, registered.
REQ-013 Port busy  output  1  high whenever state is not IDLE.
REQ-014 Port last_grant  output  1  owner of the most recent grant (0 = A, 1 = B).

Function
REQ-015 States SHALL be IDLE, SETUP, COMMIT; no other reachable states.
REQ-016 IDLE: no req -> stay IDLE; any req -> grant one requester, capture its addr/data into wr_addr/wr_data, go SETUP.
REQ-017 Only A requesting -> grant A; only B requesting -> grant B.
REQ-018 Both requesting -> grant the requester not equal to last_grant (round-robin).
REQ-019 last_grant SHALL update on the IDLE->SETUP edge to the granted requester.
REQ-020 SETUP: wr_addr/wr_data held, wr_en = 0; unconditionally go COMMIT next cycle.
REQ-021 COMMIT: wr_en = 1, granted requester's ack = 1, other ack = 0; go IDLE next cycle.
REQ-022 Latency: req sampled high in IDLE at cycle N -> wr_en and ack at cycle N+2; peak throughput one write per 3 cycles.
REQ-023 addr/data changes after the capture edge SHALL NOT affect the in-flight write.
REQ-024 Requester SHALL deassert req on the edge ending its ack cycle; req high in IDLE is always a new request.
REQ-025 Requests arriving during SETUP/COMMIT SHALL be ignored until IDLE; no request latching.
REQ-026 a_ack and b_ack SHALL never be high in the same cycle; ack never high outside COMMIT.
REQ-027 wr_addr/wr_data SHALL hold their last values in IDLE; wr_en = 0 in IDLE and SETUP.

Reset
REQ-028 rst high at an edge: state = IDLE, wr_en = 0, wr_addr = 0, wr_data = 0, a_ack = 0, b_ack = 0, busy = 0, last_grant = 1 (A wins the first tie).
REQ-029 rst in SETUP or COMMIT SHALL abort the write: no wr_en, no ack on the following cycles.
REQ-030 rst SHALL take priority over all requests in the same cycle.

Structure
REQ-031 Shared package SHALL hold the state encoding (2-bit, IDLE = 0, SETUP = 1, COMMIT = 2), the default DATA_W/ADDR_W constants and the grant encoding (GRANT_A = 0, GRANT_B = 1).
REQ-032 One sub-module, arb_rr2, SHALL be combinational: inputs a_req, b_req, last_grant; output grant id and grant-valid.
REQ-033 All outputs SHALL be driven from registers; no combinational path from inputs to outputs.

Verification
REQ-034 Reset: rst = 1 for 2 cycles with a_req = b_req = 1 -> wr_en = 0, acks = 0, busy = 0, last_grant = 1, wr_addr = 0.
REQ-035 Single A: a_req = 1, a_addr = 3, a_data = 8'hA5 at cycle N -> cycle N+2: wr_en = 1, wr_addr = 3, wr_data = 8'hA5, a_ack = 1, b_ack = 0.
REQ-036 Tie: a_req = b_req = 1 held (req dropped only after own ack) -> grant order A, B, A; acks at cycles N+2, N+5, N+8.
REQ-037 Stability: change a_data from 8'h11 to 8'h22 in the SETUP cycle -> committed wr_data = 8'h11.
REQ-038 Abort: B granted (addr 5), rst = 1 during SETUP -> no wr_en, no b_ack; state IDLE, last_grant = 1.
REQ-039 Late request: b_req rises during A's COMMIT -> ignored that cycle; B granted from the next IDLE, b_ack 2 cycles after that IDLE.

Source files
------------

// File: rtl/regbank_write_arbiter_pkg.sv
// Shared encodings for the two-requester register-bank write arbiter:
// FSM states, grant ids and default bank geometry.
package regbank_write_arbiter_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 3;

   localparam logic GRANT_A = 1'b0;
   localparam logic GRANT_B = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_COMMIT = 2'd2
   } state_e;

endpackage

// File: rtl/regbank_write_arbiter_arb_rr2.sv
// Two-way round-robin pick: on a tie the requester that did not win last
// time is chosen; a lone requester always wins.
module arb_rr2
   import regbank_write_arbiter_pkg::*;
(
   input  logic a_req,
   input  logic b_req,
   input  logic last_grant,
   output logic grant,
   output logic grant_vld
);

   always_comb begin
      grant     = GRANT_A;
      grant_vld = a_req | b_req;
      if (a_req && b_req)
         grant = (last_grant == GRANT_A) ? GRANT_B : GRANT_A;
      else if (b_req)
         grant = GRANT_B;
   end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Arbitrates A/B writes into a flip-flop bank: IDLE captures the winner's
// addr/data, SETUP holds them, COMMIT pulses wr_en and the winner's ack.
module regbank_write_arbiter
   import regbank_write_arbiter_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ack,
   input  logic              b_req,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ack,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              last_grant
);

   state_e              state_q, state_d;
   logic                lg_q, lg_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                a_ack_q, a_ack_d;
   logic                b_ack_q, b_ack_d;
   logic                busy_q, busy_d;
   logic                grant, grant_vld;

   arb_rr2 u_arb (
      .a_req      (a_req),
      .b_req      (b_req),
      .last_grant (lg_q),
      .grant      (grant),
      .grant_vld  (grant_vld)
   );

   // lg_q doubles as the owner of the in-flight write, since it is
   // updated on the capture edge and held until the next grant.
   always_comb begin
      state_d   = state_q;
      lg_d      = lg_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_en_d   = 1'b0;
      a_ack_d   = 1'b0;
      b_ack_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               state_d   = S_SETUP;
               lg_d      = grant;
               wr_addr_d = (grant == GRANT_B) ? b_addr : a_addr;
               wr_data_d = (grant == GRANT_B) ? b_data : a_data;
            end
         end
         S_SETUP: begin
            state_d = S_COMMIT;
            wr_en_d = 1'b1;
            a_ack_d = (lg_q == GRANT_A);
            b_ack_d = (lg_q == GRANT_B);
         end
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         lg_q      <= GRANT_B;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lg_q      <= lg_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
         busy_q    <= busy_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign a_ack      = a_ack_q;
   assign b_ack      = b_ack_q;
   assign busy       = busy_q;
   assign last_grant = lg_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench: a vector table for reset/single/tie traffic, then
// hand-written stability, abort and late-request sequences.
module tb_regbank_write_arbiter;

   logic       clk = 1'b0;
   logic       rst, a_req, b_req;
   logic [2:0] a_addr, b_addr;
   logic [7:0] a_data, b_data;
   logic       a_ack, b_ack, wr_en, busy, last_grant;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   regbank_write_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
      .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .last_grant(last_grant)
   );

   typedef struct {
      logic       rst, a_req;
      logic [2:0] a_addr;
      logic [7:0] a_data;
      logic       b_req;
      logic [2:0] b_addr;
      logic [7:0] b_data;
      logic       e_wr_en;
      logic [2:0] e_addr;
      logic [7:0] e_data;
      logic       e_aack, e_back, e_busy, e_lg;
   } vec_t;

   vec_t tbl[18];

   function automatic vec_t mk(input logic r, input logic ar, input logic [2:0] aa,
                               input logic [7:0] ad, input logic br, input logic [2:0] ba,
                               input logic [7:0] bd, input logic we, input logic [2:0] ea,
                               input logic [7:0] ed, input logic aak, input logic bak,
                               input logic bs, input logic lg);
      vec_t v;
      v.rst = r; v.a_req = ar; v.a_addr = aa; v.a_data = ad;
      v.b_req = br; v.b_addr = ba; v.b_data = bd;
      v.e_wr_en = we; v.e_addr = ea; v.e_data = ed;
      v.e_aack = aak; v.e_back = bak; v.e_busy = bs; v.e_lg = lg;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic ar, input logic [2:0] aa, input logic [7:0] ad,
                        input logic br, input logic [2:0] ba, input logic [7:0] bd);
      @(negedge clk);
      rst = r; a_req = ar; a_addr = aa; a_data = ad;
      b_req = br; b_addr = ba; b_data = bd;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic we, input logic [2:0] ea,
                             input logic [7:0] ed, input logic aak, input logic bak,
                             input logic bs, input logic lg);
      chk({tag, ".wr_en"}, 32'(wr_en), 32'(we));
      chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(ea));
      chk({tag, ".wr_data"}, 32'(wr_data), 32'(ed));
      chk({tag, ".a_ack"}, 32'(a_ack), 32'(aak));
      chk({tag, ".b_ack"}, 32'(b_ack), 32'(bak));
      chk({tag, ".busy"}, 32'(busy), 32'(bs));
      chk({tag, ".last_grant"}, 32'(last_grant), 32'(lg));
   endtask

   initial begin
      rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
      a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;

      //             rst ar aa   ad     br ba   bd     we ea   ed     aak bak bsy lg
      tbl[0]  = mk(1, 1, 3'd7, 8'hFF, 1, 3'd7, 8'hFF, 0, 3'd0, 8'h00, 0, 0, 0, 1);
      tbl[1]  = mk(1, 1, 3'd7, 8'hFF, 1, 3'd7, 8'hFF, 0, 3'd0, 8'h00, 0, 0, 0, 1);
      tbl[2]  = mk(0, 1, 3'd3, 8'hA5, 0, 3'd0, 8'h00, 0, 3'd3, 8'hA5, 0, 0, 1, 0);
      tbl[3]  = mk(0, 1, 3'd3, 8'hA5, 0, 3'd0, 8'h00, 1, 3'd3, 8'hA5, 1, 0, 1, 0);
      tbl[4]  = mk(0, 1, 3'd3, 8'hA5, 0, 3'd0, 8'h00, 0, 3'd3, 8'hA5, 0, 0, 0, 0);
      tbl[5]  = mk(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd3, 8'hA5, 0, 0, 0, 0);
      tbl[6]  = mk(0, 0, 3'd0, 8'h00, 1, 3'd6, 8'h3C, 0, 3'd6, 8'h3C, 0, 0, 1, 1);
      tbl[7]  = mk(0, 0, 3'd0, 8'h00, 1, 3'd6, 8'h3C, 1, 3'd6, 8'h3C, 0, 1, 1, 1);
      tbl[8]  = mk(0, 0, 3'd0, 8'h00, 1, 3'd6, 8'h3C, 0, 3'd6, 8'h3C, 0, 0, 0, 1);
      tbl[9]  = mk(0, 1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0, 3'd1, 8'h11, 0, 0, 1, 0);
      tbl[10] = mk(0, 1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 1, 3'd1, 8'h11, 1, 0, 1, 0);
      tbl[11] = mk(0, 1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0, 3'd1, 8'h11, 0, 0, 0, 0);
      tbl[12] = mk(0, 1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0, 3'd2, 8'h22, 0, 0, 1, 1);
      tbl[13] = mk(0, 1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 1, 3'd2, 8'h22, 0, 1, 1, 1);
      tbl[14] = mk(0, 1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0, 3'd2, 8'h22, 0, 0, 0, 1);
      tbl[15] = mk(0, 1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0, 3'd1, 8'h11, 0, 0, 1, 0);
      tbl[16] = mk(0, 1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 1, 3'd1, 8'h11, 1, 0, 1, 0);
      tbl[17] = mk(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd1, 8'h11, 0, 0, 0, 0);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].a_req, tbl[i].a_addr, tbl[i].a_data,
               tbl[i].b_req, tbl[i].b_addr, tbl[i].b_data);
         expect_out($sformatf("vec%0d", i), tbl[i].e_wr_en, tbl[i].e_addr, tbl[i].e_data,
                    tbl[i].e_aack, tbl[i].e_back, tbl[i].e_busy, tbl[i].e_lg);
      end

      // Data changed during SETUP must not reach the bank.
      drive(0, 1, 3'd4, 8'h11, 0, 3'd0, 8'h00);
      expect_out("stab_setup", 0, 3'd4, 8'h11, 0, 0, 1, 0);
      drive(0, 1, 3'd4, 8'h22, 0, 3'd0, 8'h00);
      expect_out("stab_commit", 1, 3'd4, 8'h11, 1, 0, 1, 0);
      drive(0, 1, 3'd4, 8'h22, 0, 3'd0, 8'h00);
      expect_out("stab_idle", 0, 3'd4, 8'h11, 0, 0, 0, 0);

      // Reset during SETUP kills B's write.
      drive(0, 0, 3'd0, 8'h00, 1, 3'd5, 8'h77);
      expect_out("abort_setup", 0, 3'd5, 8'h77, 0, 0, 1, 1);
      drive(1, 0, 3'd0, 8'h00, 1, 3'd5, 8'h77);
      expect_out("abort_rst", 0, 3'd0, 8'h00, 0, 0, 0, 1);
      drive(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
      expect_out("abort_after1", 0, 3'd0, 8'h00, 0, 0, 0, 1);
      drive(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
      expect_out("abort_after2", 0, 3'd0, 8'h00, 0, 0, 0, 1);

      // b_req rising in A's COMMIT is only seen from the next IDLE.
      drive(0, 1, 3'd0, 8'h01, 0, 3'd0, 8'h00);
      expect_out("late_setup", 0, 3'd0, 8'h01, 0, 0, 1, 0);
      drive(0, 1, 3'd0, 8'h01, 0, 3'd0, 8'h00);
      expect_out("late_commitA", 1, 3'd0, 8'h01, 1, 0, 1, 0);
      drive(0, 1, 3'd0, 8'h01, 1, 3'd7, 8'hEE);
      expect_out("late_idle", 0, 3'd0, 8'h01, 0, 0, 0, 0);
      drive(0, 0, 3'd0, 8'h00, 1, 3'd7, 8'hEE);
      expect_out("late_setupB", 0, 3'd7, 8'hEE, 0, 0, 1, 1);
      drive(0, 0, 3'd0, 8'h00, 1, 3'd7, 8'hEE);
      expect_out("late_commitB", 1, 3'd7, 8'hEE, 0, 1, 1, 1);
      drive(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
      expect_out("late_end", 0, 3'd7, 8'hEE, 0, 0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
